// File: rtl/acq_pkg.sv
// acq_pkg: shared types and defaults for the acquisition capture path.
//   acq_state_t  - capture controller state encoding
//   ACQ_DATA_W   - default ADC sample width
//   ACQ_ADDR_W   - default capture RAM address width
package acq_pkg;

  localparam int ACQ_DATA_W = 8;
  localparam int ACQ_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE_FILL  = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } acq_state_t;

endpackage

// File: rtl/acq_capture_ctrl_trig_detect.sv
// trig_detect: combinational level-crossing comparator.
//   last_sample - previous sample (unsigned)
//   sample      - current sample (unsigned)
//   level       - trigger threshold (unsigned)
//   slope       - 1 = rising crossing, 0 = falling crossing
//   hit         - crossing detected on this sample pair
module trig_detect #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] last_sample,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] level,
  input  logic              slope,
  output logic              hit
);

  always_comb begin
    hit = 1'b0;
    if (slope) begin
      hit = (last_sample < level) && (sample >= level);
    end else begin
      hit = (last_sample > level) && (sample <= level);
    end
  end

endmodule

// File: rtl/acq_capture_ctrl.sv
// acq_capture_ctrl: trigger-and-capture controller writing a circular capture RAM.
//   clk, reset_n      - rising-edge clock, synchronous active-low reset
//   sample            - ADC sample (updates on falling edge, sampled on rising edge)
//   arm               - start a capture (accepted only in IDLE or DONE)
//   force_trig        - trigger on the current sample regardless of level
//   trig_level/slope  - crossing threshold and direction (latched on arm)
//   pretrig_len       - samples kept before the trigger (latched on arm)
//   wr_en/addr/data   - registered RAM write port
//   busy, done        - capture in progress / buffer complete
//   trig_addr         - RAM address holding the trigger sample
//   dbg_state         - current FSM state
//
// Handshake: arm is a level sampled on a rising edge only while not busy;
// done is a level held until the next accepted arm or reset. wr_en is a
// one-cycle-per-write strobe with no back-pressure.
module acq_capture_ctrl
  import acq_pkg::*;
#(
  parameter int DATA_W = ACQ_DATA_W,
  parameter int ADDR_W = ACQ_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] pretrig_len,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output acq_state_t        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};

  acq_state_t        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] pre_len_q;
  logic [DATA_W-1:0] level_q;
  logic              slope_q;
  logic [DATA_W-1:0] last_sample;
  logic              hw_hit;
  logic              fire;
  logic              capturing;
  logic [ADDR_W-1:0] post_len;

  trig_detect #(.DATA_W(DATA_W)) u_trig (
    .last_sample (last_sample),
    .sample      (sample),
    .level       (level_q),
    .slope       (slope_q),
    .hit         (hw_hit)
  );

  // A forced and a hardware trigger in the same cycle merge into one event.
  assign fire      = hw_hit | force_trig;
  assign capturing = (state == ST_PRE_FILL) || (state == ST_WAIT_TRIG) || (state == ST_POST);
  // Writes after the trigger sample: DEPTH - pretrig_len - 1 = (DEPTH-1) - pretrig_len.
  assign post_len  = LAST_ADDR - pre_len_q;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      pre_len_q   <= '0;
      level_q     <= '0;
      slope_q     <= 1'b0;
      last_sample <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      trig_addr   <= '0;
    end else begin
      wr_en <= 1'b0;

      if (capturing) begin
        wr_en       <= 1'b1;
        wr_addr     <= ptr;
        wr_data     <= sample;
        ptr         <= ptr + ONE;  // natural wrap DEPTH-1 -> 0
        last_sample <= sample;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          // DONE is entered on the final write edge with busy still high, so
          // done/busy flip one cycle after the last wr_en cycle.
          busy <= 1'b0;
          if (state == ST_DONE) done <= 1'b1;
          if (arm) begin
            ptr         <= '0;
            cnt         <= '0;
            last_sample <= sample;
            done        <= 1'b0;
            busy        <= 1'b1;
            pre_len_q   <= pretrig_len;
            level_q     <= trig_level;
            slope_q     <= trig_slope;
            state       <= (pretrig_len == '0) ? ST_WAIT_TRIG : ST_PRE_FILL;
          end
        end

        ST_PRE_FILL: begin
          if (cnt == pre_len_q - ONE) begin
            cnt   <= '0;
            state <= ST_WAIT_TRIG;
          end else begin
            cnt <= cnt + ONE;
          end
        end

        ST_WAIT_TRIG: begin
          if (fire) begin
            trig_addr <= ptr;
            if (post_len == '0) begin
              state <= ST_DONE;
            end else begin
              cnt   <= post_len;
              state <= ST_POST;
            end
          end
        end

        ST_POST: begin
          if (cnt == ONE) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - ONE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// tb_acq_capture_ctrl: directed, table-driven bench for acq_capture_ctrl
// with a 16-entry buffer and an up-ramp ADC model restarting at 5 per capture.
module tb_acq_capture_ctrl;
  import acq_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [DATA_W-1:0] sample;
  logic              arm;
  logic              force_trig;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic [ADDR_W-1:0] pretrig_len;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] trig_addr;
  acq_state_t        dbg_state;

  acq_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample      (sample),
    .arm         (arm),
    .force_trig  (force_trig),
    .trig_level  (trig_level),
    .trig_slope  (trig_slope),
    .pretrig_len (pretrig_len),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .trig_addr   (trig_addr),
    .dbg_state   (dbg_state)
  );

  // ADC model: holds 5 while stopped, ramps +1 on each falling edge while running.
  logic adc_run;
  always @(negedge clk) begin
    if (adc_run) sample <= sample + 8'd1;
    else         sample <= 8'd5;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int pre;
    int level;
    bit slope;
    int force_at;    // pulse force_trig once this many writes are seen (-1 = never)
    int arm_at;      // pulse arm once this many writes are seen (-1 = never)
    int exp_trig;
    int exp_writes;
  } vec_t;

  vec_t vecs[6];

  // Arms with sample = 5 at the arm edge, so write k carries (6+k)%256 at address k%16.
  task automatic run_case(input int id, input vec_t v);
    int nw;
    bit prev_wr;
    bit seen_done;
    logic [ADDR_W-1:0] ta;
    adc_run     = 1'b0;
    arm         = 1'b1;
    force_trig  = 1'b0;
    pretrig_len = v.pre[ADDR_W-1:0];
    trig_level  = v.level[DATA_W-1:0];
    trig_slope  = v.slope;
    step();
    arm     = 1'b0;
    adc_run = 1'b1;
    check($sformatf("c%0d_arm_busy", id), busy, 1);
    check($sformatf("c%0d_arm_done", id), done, 0);
    check($sformatf("c%0d_arm_wr_en", id), wr_en, 0);
    nw = 0;
    prev_wr = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      force_trig = (v.force_at >= 0) && (nw == v.force_at);
      arm        = (v.arm_at >= 0) && (nw == v.arm_at);
      step();
      if (wr_en) begin
        check($sformatf("c%0d_wr_addr%0d", id, nw), wr_addr, nw % DEPTH);
        check($sformatf("c%0d_wr_data%0d", id, nw), wr_data, (6 + nw) % 256);
        check($sformatf("c%0d_wr_busy%0d", id, nw), busy, 1);
        nw++;
      end else if (!done && nw > 0) begin
        check($sformatf("c%0d_wr_gap", id), wr_en, 1);
      end
      if (done) begin
        seen_done = 1'b1;
        check($sformatf("c%0d_done_after_last_wr", id), prev_wr, 1);
        check($sformatf("c%0d_done_busy", id), busy, 0);
      end
      prev_wr = wr_en;
    end
    force_trig = 1'b0;
    arm        = 1'b0;
    check($sformatf("c%0d_done_seen", id), seen_done, 1);
    check($sformatf("c%0d_writes", id), nw, v.exp_writes);
    check($sformatf("c%0d_trig_addr", id), trig_addr, v.exp_trig);
    ta = trig_addr;
    step();
    check($sformatf("c%0d_done_held", id), done, 1);
    check($sformatf("c%0d_idle_wr_en", id), wr_en, 0);
    check($sformatf("c%0d_trig_addr_stable", id), trig_addr, ta);
  endtask

  initial begin
    //           pre lvl slope force arm  trig writes
    vecs[0] = '{4,  20,  1'b1, -1, -1,  14,  26};   // ramp trigger
    vecs[1] = '{0,  6,   1'b1, -1, -1,  0,   16};   // zero pretrigger
    vecs[2] = '{15, 30,  1'b1, -1, 10,  8,   25};   // max pretrigger, arm ignored
    vecs[3] = '{8,  100, 1'b1, -1, -1,  14,  102};  // long wait, many wraps
    vecs[4] = '{3,  10,  1'b0, -1, -1,  10,  263};  // falling crossing at 255->0
    vecs[5] = '{2,  3,   1'b0, 30, -1,  14,  44};   // no crossing, forced trigger

    reset_n     = 1'b0;
    adc_run     = 1'b0;
    arm         = 1'b0;
    force_trig  = 1'b0;
    trig_level  = '0;
    trig_slope  = 1'b0;
    pretrig_len = '0;
    step();
    step();
    reset_n = 1'b1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_state", dbg_state, ST_IDLE);
    step();
    check("idle_no_write", wr_en, 0);

    for (int i = 0; i < 6; i++) run_case(i, vecs[i]);

    // Reset in the middle of POST, then re-arm from IDLE.
    begin
      int nw;
      adc_run     = 1'b0;
      arm         = 1'b1;
      pretrig_len = 4'd4;
      trig_level  = 8'd20;
      trig_slope  = 1'b1;
      step();
      arm     = 1'b0;
      adc_run = 1'b1;
      nw = 0;
      for (int c = 0; c < 100 && nw < 18; c++) begin
        step();
        if (wr_en) nw++;
      end
      check("midpost_reach", nw, 18);
      check("midpost_state", dbg_state, ST_POST);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check("midrst_wr_en", wr_en, 0);
      check("midrst_wr_addr", wr_addr, 0);
      check("midrst_wr_data", wr_data, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_trig_addr", trig_addr, 0);
      check("midrst_state", dbg_state, ST_IDLE);
      step();
      check("midrst_idle_wr_en", wr_en, 0);
      run_case(6, vecs[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
